mix_columns_iter: RTL and testbench

- Forward AES MixColumns for the encryption datapath. It is the forward counterpart of the inverse-MixColumns byte-multiplier path on the decrypt side.
- Accepts one 128-bit state through a valid/ready handshake and processes it iteratively, COLS_PER_CYCLE columns per clock. It then holds the result until the consumer accepts it.
- A bypass flag passes the state through unchanged, for the final AES round, which omits MixColumns.

---
 rtl/mix_columns_iter_pkg.sv | 26 ++
 rtl/mix_columns_iter_if.sv | 39 +++
 rtl/mix_columns_iter_mix_column_word.sv | 40 ++++
 rtl/mix_columns_iter.sv | 118 +++++++++++
 tb/tb_mix_columns_iter.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_iter_pkg
//  Description : Shared AES constants and FSM encoding for the forward
//                MixColumns block.
//  Revision    : 1.0 - initial release
// ============================================================================
package mix_columns_iter_pkg;

    // Field reduction constant for GF(2^8) with polynomial x^8+x^4+x^3+x+1
    localparam logic [7:0] GF_POLY = 8'h1B;

    // Datapath widths
    localparam int STATE_W = 128;
    localparam int COL_W   = 32;
    localparam int BYTE_W  = 8;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : mix_columns_iter_pkg
`default_nettype wire

// File: rtl/mix_columns_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_iter_if
//  Description : Input/output valid-ready channels of the MixColumns block.
//                Vectors are [0:127]: byte k occupies bits [8k:8k+7], MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_bypass;
    logic [0:127] value_i;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] value_o;

    // Block side
    modport slave (
        input  in_valid,
        input  in_bypass,
        input  value_i,
        input  out_ready,
        output in_ready,
        output out_valid,
        output value_o
    );

    // Producer/consumer side
    modport master (
        output in_valid,
        output in_bypass,
        output value_i,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  value_o
    );
endinterface : mix_columns_iter_if
`default_nettype wire

// File: rtl/mix_columns_iter_mix_column_word.sv
`default_nettype none
// ============================================================================
//  Module      : mix_column_word
//  Description : Combinational forward MixColumns of one 32-bit column
//                (row 0 byte in bits [0:7]).
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_column_word
    import mix_columns_iter_pkg::*;
(
    input  logic [0:31] col_i,
    output logic [0:31] col_o
);

    // Multiply by 2 in GF(2^8); x[7] is the MSB of the byte
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    endfunction

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_x0, w_x1, w_x2, w_x3;

    assign w_a0 = col_i[0:7];
    assign w_a1 = col_i[8:15];
    assign w_a2 = col_i[16:23];
    assign w_a3 = col_i[24:31];

    assign w_x0 = xtime(w_a0);
    assign w_x1 = xtime(w_a1);
    assign w_x2 = xtime(w_a2);
    assign w_x3 = xtime(w_a3);

    // 3x is expressed as 2x ^ x
    assign col_o[0:7]   = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
    assign col_o[8:15]  = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
    assign col_o[16:23] = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
    assign col_o[24:31] = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule : mix_column_word
`default_nettype wire

// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_iter
//  Description : Iterative forward AES MixColumns. Accepts one 128-bit state,
//                processes COLS_PER_CYCLE columns per clock and holds the
//                result until accepted. Bypass passes the state unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_iter
    import mix_columns_iter_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)(
    input  logic             clk,
    input  logic             rst_n,
    mix_columns_iter_if.slave bus
);

    localparam int         ITER     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(ITER - 1);

    state_e       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [0:127] data_q;
    logic [0:127] res_q, res_d;
    logic [0:127] value_q, value_d;
    logic         w_accept;
    logic         w_last;

    logic [1:0]   w_col_idx [COLS_PER_CYCLE];
    logic [0:31]  w_col_in  [COLS_PER_CYCLE];
    logic [0:31]  w_col_out [COLS_PER_CYCLE];

    assign w_accept = bus.in_valid && (state_q == ST_IDLE);
    assign w_last   = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);

    // Column engines: engine j handles column cnt*COLS_PER_CYCLE + j
    generate
        for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
            assign w_col_idx[j] = 2'((int'(cnt_q) * COLS_PER_CYCLE) + j);
            assign w_col_in[j]  = data_q[{w_col_idx[j], 5'b0} +: 32];

            mix_column_word u_mcw (
                .col_i (w_col_in[j]),
                .col_o (w_col_out[j])
            );
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: bypass skips straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept)      state_d = bus.in_bypass ? ST_DONE : ST_BUSY;
            ST_BUSY: if (w_last)        state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake flags decoded from the registered state
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
    end

    // Datapath next-state: partial results accumulate in res, value_o only
    // changes on acceptance (bypass) or on the edge that enters DONE
    always_comb begin
        cnt_d   = cnt_q;
        res_d   = res_q;
        value_d = value_q;
        if (w_accept) begin
            cnt_d = 2'd0;
            if (bus.in_bypass) begin
                value_d = bus.value_i;
            end
        end else if (state_q == ST_BUSY) begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                res_d[{w_col_idx[j], 5'b0} +: 32] = w_col_out[j];
            end
            cnt_d = cnt_q + 2'd1;
            if (w_last) begin
                value_d = res_d;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            data_q  <= '0;
            res_q   <= '0;
            value_q <= '0;
        end else begin
            if (w_accept) begin
                data_q <= bus.value_i;
            end
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            value_q <= value_d;
        end
    end

    assign bus.value_o = value_q;

endmodule : mix_columns_iter
`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mix_columns_iter
//  Description : Directed self-checking bench for mix_columns_iter with
//                COLS_PER_CYCLE = 1, 2 and 4 driven in lockstep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_columns_iter;

    localparam logic [127:0] C_FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] C_FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] C_COL_IN   = 128'hdb135345f20a225c010101012d26314c;
    localparam logic [127:0] C_COL_OUT  = 128'h8e4da1bc9fdc589d010101014d7ebdf8;
    localparam logic [127:0] C_BYP      = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_JUNK     = 128'hdeadbeefcafef00d0123456789abcdef;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tb_in_valid = 1'b0;
    logic         tb_bypass = 1'b0;
    logic [0:127] tb_value = '0;
    logic         tb_out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    mix_columns_iter_if if1();
    mix_columns_iter_if if2();
    mix_columns_iter_if if4();

    assign if1.in_valid  = tb_in_valid;
    assign if1.in_bypass = tb_bypass;
    assign if1.value_i   = tb_value;
    assign if1.out_ready = tb_out_ready;
    assign if2.in_valid  = tb_in_valid;
    assign if2.in_bypass = tb_bypass;
    assign if2.value_i   = tb_value;
    assign if2.out_ready = tb_out_ready;
    assign if4.in_valid  = tb_in_valid;
    assign if4.in_bypass = tb_bypass;
    assign if4.value_i   = tb_value;
    assign if4.out_ready = tb_out_ready;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; stimulus and sampling happen 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one state on all three blocks and measure each latency
    task automatic run_all(input string tag, input logic [127:0] vin, input logic byp,
                           input logic [127:0] vexp, input int l1x, input int l2x, input int l4x);
        int l1, l2, l4;
        l1 = 0; l2 = 0; l4 = 0;
        chk({tag, "_rdy_before"}, 128'(if1.in_ready), 128'd1);
        tb_value    = vin;
        tb_bypass   = byp;
        tb_in_valid = 1'b1;
        step();
        tb_in_valid = 1'b0;
        tb_bypass   = 1'b0;
        tb_value    = C_JUNK;
        for (int n = 1; n <= 6; n++) begin
            chk({tag, "_rdy_low"}, 128'(if1.in_ready), 128'd0);
            step();
            if (if1.out_valid && l1 == 0) l1 = n;
            if (if2.out_valid && l2 == 0) l2 = n;
            if (if4.out_valid && l4 == 0) l4 = n;
        end
        chk({tag, "_lat1"}, 128'(l1), 128'(l1x));
        chk({tag, "_lat2"}, 128'(l2), 128'(l2x));
        chk({tag, "_lat4"}, 128'(l4), 128'(l4x));
        chk({tag, "_val1"}, if1.value_o, vexp);
        chk({tag, "_val2"}, if2.value_o, vexp);
        chk({tag, "_val4"}, if4.value_o, vexp);
    endtask

    // Complete the output handshake on all blocks
    task automatic release_all(input string tag);
        tb_out_ready = 1'b1;
        step();
        tb_out_ready = 1'b0;
        chk({tag, "_ovalid_drop"}, 128'(if1.out_valid), 128'd0);
        chk({tag, "_ovalid_drop4"}, 128'(if4.out_valid), 128'd0);
        chk({tag, "_rdy_back"}, 128'(if1.in_ready), 128'd1);
    endtask

    // Wait for dut1 out_valid with a cycle budget; returns 0 on timeout
    task automatic wait_valid1(output int lat);
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (if1.out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) step();
        chk("rst_rdy", 128'(if1.in_ready), 128'd1);
        chk("rst_ovalid", 128'(if1.out_valid), 128'd0);
        chk("rst_value", if1.value_o, 128'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_rdy", 128'(if1.in_ready), 128'd1);
        chk("post_rst_ovalid2", 128'(if2.out_valid), 128'd0);

        // out_ready while idle must not disturb anything
        tb_out_ready = 1'b1;
        step();
        tb_out_ready = 1'b0;
        chk("idle_oready_ignored", 128'(if1.out_valid), 128'd0);

        run_all("fips", C_FIPS_IN, 1'b0, C_FIPS_OUT, 4, 2, 1);
        release_all("fips");
        run_all("cols", C_COL_IN, 1'b0, C_COL_OUT, 4, 2, 1);
        release_all("cols");

        // Bypass then 10 cycles of backpressure with in_valid pulses
        run_all("byp", C_BYP, 1'b1, C_BYP, 1, 1, 1);
        for (int n = 0; n < 10; n++) begin
            tb_in_valid = n[0];
            tb_value    = C_JUNK;
            step();
            chk("bp_ovalid", 128'(if1.out_valid), 128'd1);
            chk("bp_value", if1.value_o, C_BYP);
            chk("bp_rdy", 128'(if1.in_ready), 128'd0);
        end
        tb_in_valid = 1'b0;
        release_all("bp");

        // Back-to-back with in_valid held high and out_ready held high
        tb_value     = C_FIPS_IN;
        tb_in_valid  = 1'b1;
        tb_out_ready = 1'b1;
        step();
        chk("b2b_acc_a", 128'(if1.in_ready), 128'd0);
        tb_value = C_COL_IN;
        wait_valid1(lat);
        chk("b2b_lat_a", 128'(lat), 128'd4);
        chk("b2b_val_a", if1.value_o, C_FIPS_OUT);
        step();
        chk("b2b_hs_ovalid", 128'(if1.out_valid), 128'd0);
        chk("b2b_hs_rdy", 128'(if1.in_ready), 128'd1);
        step();
        chk("b2b_acc_b", 128'(if1.in_ready), 128'd0);
        tb_in_valid = 1'b0;
        wait_valid1(lat);
        chk("b2b_lat_b", 128'(lat), 128'd4);
        chk("b2b_val_b", if1.value_o, C_COL_OUT);
        step();
        tb_out_ready = 1'b0;
        chk("b2b_done", 128'(if1.in_ready), 128'd1);

        // Asynchronous reset while dut1 is BUSY with counter = 2
        tb_value    = C_FIPS_IN;
        tb_in_valid = 1'b1;
        step();
        tb_in_valid = 1'b0;
        step();
        step();
        chk("mid_busy_ovalid", 128'(if1.out_valid), 128'd0);
        chk("mid_busy_rdy", 128'(if1.in_ready), 128'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", 128'(if1.in_ready), 128'd1);
        chk("arst_ovalid", 128'(if1.out_valid), 128'd0);
        chk("arst_value", if1.value_o, 128'd0);
        #2 rst_n = 1'b1;
        step();
        chk("arst_rel_rdy", 128'(if1.in_ready), 128'd1);
        chk("arst_rel_ovalid", 128'(if1.out_valid), 128'd0);
        chk("arst_rel_value", if1.value_o, 128'd0);
        run_all("after_rst", C_COL_IN, 1'b0, C_COL_OUT, 4, 2, 1);
        release_all("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mix_columns_iter
`default_nettype wire
